// File: rtl/alu_pkg.sv
// Shared types for the ALU command issuer: opcodes, FSM states and the queued command.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_MUL  = 4'd2,
    ALU_DIV  = 4'd3,
    ALU_SHL  = 4'd4,
    ALU_SHR  = 4'd5,
    ALU_ROL  = 4'd6,
    ALU_ROR  = 4'd7,
    ALU_AND  = 4'd8,
    ALU_OR   = 4'd9,
    ALU_XOR  = 4'd10,
    ALU_ADDA = 4'd11,
    ALU_MULA = 4'd12,
    ALU_MAC  = 4'd13,
    ALU_GTH  = 4'd14,
    ALU_LTH  = 4'd15
  } alu_op_e;

  localparam alu_op_e OP_DIV = ALU_DIV;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } issuer_state_e;

  typedef struct packed {
    alu_op_e    sel;
    logic [7:0] a;
    logic [7:0] b;
  } alu_cmd_t;

  // A divide by zero never reaches the ALU; the issuer answers it directly.
  function automatic logic is_div_zero(alu_cmd_t cmd);
    return (cmd.sel == OP_DIV) && (cmd.b == 8'h00);
  endfunction

endpackage

// File: rtl/alu_issuer_if.sv
// Command and response handshake bundle between a host and the ALU issuer.
interface alu_issuer_if #(
  parameter int TAG_W = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_sel;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  logic [TAG_W-1:0] cmd_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_data;
  logic             rsp_err;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_tag
  );

  modport slave (
    input  cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_tag
  );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; pushes are refused when full even if a pop shares the edge.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_issuer.sv
// Front end for the registered ALU: queues commands, issues one at a time,
// waits out the ALU latency and returns results in order.
//
// state | meaning
// IDLE  | waiting for a queued command; pops the head when one exists
// ISSUE | operands on the ALU ports; ALU samples them at the exit edge
// WAIT  | counting down the ALU latency before capturing alu_out
// RESP  | response presented; held until rsp_ready
module alu_issuer
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_issuer_if.slave bus,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_sel,
  input  logic [7:0]  alu_out,
  output logic        busy,
  output logic [15:0] op_count
);
  localparam int CW    = $bits(alu_cmd_t) + TAG_W;
  localparam int CNT_W = $clog2(ALU_LAT + 1);

  issuer_state_e         state_q, state_d;
  logic [CW-1:0]         fifo_wdata, fifo_rdata;
  logic                  fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  alu_cmd_t              head_cmd;
  logic [TAG_W-1:0]      head_tag;
  logic [CNT_W-1:0]      wait_cnt;
  logic [7:0]            rsp_data;
  logic                  rsp_err;
  logic [TAG_W-1:0]      rsp_tag;
  logic                  pop, load_alu, load_dz, load_wait, capture, done;

  assign fifo_wdata           = {bus.cmd_sel, bus.cmd_a, bus.cmd_b, bus.cmd_tag};
  assign {head_cmd, head_tag} = fifo_rdata;

  alu_cmd_fifo #(.DEPTH(DEPTH), .W(CW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.cmd_valid),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.cmd_ready = !fifo_full;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_err   = rsp_err;
  assign bus.rsp_tag   = rsp_tag;
  assign busy          = (state_q != S_IDLE) || (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    load_alu  = 1'b0;
    load_dz   = 1'b0;
    load_wait = 1'b0;
    capture   = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (is_div_zero(head_cmd)) begin
            load_dz = 1'b1;
            state_d = S_RESP;
          end else begin
            load_alu = 1'b1;
            state_d  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        load_wait = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt == CNT_W'(1)) begin
          capture = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a    <= 8'h00;
      alu_b    <= 8'h00;
      alu_sel  <= 4'h0;
      wait_cnt <= '0;
      rsp_data <= 8'h00;
      rsp_err  <= 1'b0;
      rsp_tag  <= '0;
      op_count <= 16'h0000;
    end else begin
      if (load_alu) begin
        alu_a   <= head_cmd.a;
        alu_b   <= head_cmd.b;
        alu_sel <= head_cmd.sel;
      end
      // The tag only becomes visible in RESP, so latching it at pop is safe.
      if (pop) rsp_tag <= head_tag;
      if (load_dz) begin
        rsp_data <= 8'hFF;
        rsp_err  <= 1'b1;
      end
      if (load_wait)               wait_cnt <= CNT_W'(ALU_LAT);
      else if (state_q == S_WAIT)  wait_cnt <= wait_cnt - CNT_W'(1);
      if (capture) begin
        rsp_data <= alu_out;
        rsp_err  <= 1'b0;
      end
      if (done) op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_issuer.sv
// Directed bench for alu_issuer with a registered ALU stand-in and an in-order response model.
module tb_alu_issuer;
  import alu_pkg::*;

  localparam int TAG_W = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  alu_a, alu_b, alu_out;
  logic [3:0]  alu_sel;
  logic        busy;
  logic [15:0] op_count;

  alu_issuer_if #(.TAG_W(TAG_W)) bus ();

  alu_issuer #(.DEPTH(4), .TAG_W(TAG_W), .ALU_LAT(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_sel  (alu_sel),
    .alu_out  (alu_out),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  // Non-accumulating opcodes only; the accumulating ones are never issued here.
  function automatic logic [7:0] alu_fn(logic [3:0] s, logic [7:0] a, logic [7:0] b);
    case (s)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a * b;
      4'd3:    return (b == 8'h00) ? 8'hFF : a / b;
      4'd4:    return a << 1;
      4'd5:    return a >> 1;
      4'd6:    return {a[6:0], a[7]};
      4'd7:    return {a[0], a[7:1]};
      4'd8:    return a & b;
      4'd9:    return a | b;
      4'd10:   return a ^ b;
      4'd14:   return (a > b) ? 8'hFF : 8'h00;
      4'd15:   return (a < b) ? 8'hFF : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) alu_out <= alu_fn(alu_sel, alu_a, alu_b);

  typedef struct {
    logic [7:0]       data;
    logic             err;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  typedef struct packed {
    logic [3:0] s;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
  } vec_t;

  rsp_t exp_q[$];
  rsp_t got_q[$];
  int   exp_ops = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  logic             prev_valid = 1'b0;
  logic             prev_hs = 1'b0;
  logic [7:0]       prev_data;
  logic             prev_err;
  logic [TAG_W-1:0] prev_tag;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Response model: each accepted command yields exactly one in-order response.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      rsp_t e;
      check("busy", 32'(busy), 32'(exp_q.size() != 0));
      check("op_count", 32'(op_count), 32'(exp_ops));
      if (prev_valid && !prev_hs) begin
        check("rsp_valid_held", 32'(bus.rsp_valid), 1);
        check("rsp_data_stable", 32'(bus.rsp_data), 32'(prev_data));
        check("rsp_err_stable", 32'(bus.rsp_err), 32'(prev_err));
        check("rsp_tag_stable", 32'(bus.rsp_tag), 32'(prev_tag));
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'(bus.rsp_valid), 0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
          check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          check("rsp_tag", 32'(bus.rsp_tag), 32'(e.tag));
        end
        e.data = bus.rsp_data;
        e.err  = bus.rsp_err;
        e.tag  = bus.rsp_tag;
        got_q.push_back(e);
        exp_ops++;
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        e.err  = (bus.cmd_sel == 4'd3) && (bus.cmd_b == 8'h00);
        e.data = e.err ? 8'hFF : alu_fn(bus.cmd_sel, bus.cmd_a, bus.cmd_b);
        e.tag  = bus.cmd_tag;
        exp_q.push_back(e);
      end
      prev_valid = bus.rsp_valid;
      prev_hs    = bus.rsp_valid && bus.rsp_ready;
      prev_data  = bus.rsp_data;
      prev_err   = bus.rsp_err;
      prev_tag   = bus.rsp_tag;
    end
  end

  task automatic push(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                      input logic [TAG_W-1:0] t);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_sel   = s;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_tag   = t;
    while (!bus.cmd_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.cmd_ready) check("push_timeout", 32'(bus.cmd_ready), 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic accept_one();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.rsp_ready = 1'b1;
    while ((busy || bus.rsp_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    bus.rsp_ready = 1'b0;
    check("drain_done", 32'(busy), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    exp_ops = 0;
  endtask

  task automatic check_reset_state(input string tn);
    check({tn, "_busy"}, 32'(busy), 0);
    check({tn, "_cmd_ready"}, 32'(bus.cmd_ready), 1);
    check({tn, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    check({tn, "_alu_a"}, 32'(alu_a), 0);
    check({tn, "_alu_b"}, 32'(alu_b), 0);
    check({tn, "_alu_sel"}, 32'(alu_sel), 0);
    check({tn, "_rsp_data"}, 32'(bus.rsp_data), 0);
    check({tn, "_rsp_err"}, 32'(bus.rsp_err), 0);
    check({tn, "_rsp_tag"}, 32'(bus.rsp_tag), 0);
    check({tn, "_op_count"}, 32'(op_count), 0);
  endtask

  vec_t t3[6] = '{
    '{4'd0,  8'h20, 8'h22, 8'h42},
    '{4'd1,  8'h50, 8'h10, 8'h40},
    '{4'd2,  8'h07, 8'h06, 8'h2A},
    '{4'd8,  8'hF0, 8'h3C, 8'h30},
    '{4'd10, 8'hAA, 8'h0F, 8'hA5},
    '{4'd3,  8'h64, 8'h05, 8'h14}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    bus.cmd_valid = 1'b0;
    bus.cmd_sel   = 4'h0;
    bus.cmd_a     = 8'h00;
    bus.cmd_b     = 8'h00;
    bus.cmd_tag   = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: reset state, then ADD with latency and op_count.
    @(negedge clk);
    check_reset_state("t1_reset");
    @(posedge clk); #1;
    push(4'd0, 8'h05, 8'h03, 4'd1);
    wait_valid(lat);
    check("t1_latency", 32'(lat), 3);
    check("t1_data", 32'(bus.rsp_data), 32'h08);
    check("t1_tag", 32'(bus.rsp_tag), 1);
    check("t1_err", 32'(bus.rsp_err), 0);
    accept_one();
    check("t1_op_count", 32'(op_count), 1);

    // 2: divide by zero is answered without touching the ALU ports.
    push(4'd3, 8'h10, 8'h00, 4'd2);
    wait_valid(lat);
    check("t2_latency", 32'(lat), 1);
    check("t2_data", 32'(bus.rsp_data), 32'hFF);
    check("t2_err", 32'(bus.rsp_err), 1);
    check("t2_tag", 32'(bus.rsp_tag), 2);
    check("t2_alu_sel", 32'(alu_sel), 0);
    check("t2_alu_a", 32'(alu_a), 32'h05);
    check("t2_alu_b", 32'(alu_b), 32'h03);
    accept_one();

    // 3: back-pressure fills the FIFO, then six in-order responses.
    do_reset();
    got_q.delete();
    for (int i = 0; i < 5; i++) begin
      push(t3[i].s, t3[i].a, t3[i].b, TAG_W'(i + 3));
      if (i == 3) check("t3_ready_after4", 32'(bus.cmd_ready), 1);
    end
    check("t3_ready_after5", 32'(bus.cmd_ready), 0);
    bus.rsp_ready = 1'b1;
    push(t3[5].s, t3[5].a, t3[5].b, TAG_W'(8));
    drain();
    check("t3_rsp_count", 32'(got_q.size()), 6);
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      check("t3_data", 32'(got_q[i].data), 32'(t3[i].r));
      check("t3_tag", 32'(got_q[i].tag), 32'(i + 3));
    end
    check("t3_op_count", 32'(op_count), 6);

    // 4: compare ops with the response held under back-pressure.
    push(4'd14, 8'hC8, 8'h64, 4'd9);
    push(4'd15, 8'hC8, 8'h64, 4'd10);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      check("t4_gth_valid", 32'(bus.rsp_valid), 1);
      check("t4_gth_data", 32'(bus.rsp_data), 32'hFF);
      check("t4_gth_tag", 32'(bus.rsp_tag), 9);
      @(posedge clk); #1;
    end
    accept_one();
    wait_valid(lat);
    check("t4_lth_data", 32'(bus.rsp_data), 32'h00);
    check("t4_lth_tag", 32'(bus.rsp_tag), 10);
    accept_one();
    check("t4_op_count", 32'(op_count), 8);

    // 5: reset while waiting on the ALU with two commands queued.
    push(4'd0, 8'h01, 8'h01, 4'd1);
    push(4'd1, 8'h09, 8'h02, 4'd2);
    push(4'd2, 8'h03, 8'h03, 4'd3);
    check("t5_in_wait", 32'(dut.state_q == S_WAIT), 1);
    check("t5_queued", 32'(dut.fifo_count), 2);
    check("t5_alu_a_before", 32'(alu_a), 1);
    do_reset();
    check_reset_state("t5_reset");
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) seen++;
    end
    check("t5_no_rsp", 32'(seen), 0);

    // 6: push and pop on the same edge with two entries queued.
    got_q.delete();
    push(4'd0, 8'h02, 8'h03, 4'd1);
    push(4'd1, 8'h09, 8'h04, 4'd2);
    push(4'd10, 8'h3C, 8'h0F, 4'd3);
    wait_valid(lat);
    check("t6_count_before", 32'(dut.fifo_count), 2);
    accept_one();
    push(4'd9, 8'h0F, 8'h30, 4'd4);
    check("t6_count_after", 32'(dut.fifo_count), 2);
    check("t6_popped", 32'(dut.state_q == S_ISSUE), 1);
    drain();
    check("t6_rsp_count", 32'(got_q.size()), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      check("t6_tag_order", 32'(got_q[i].tag), 32'(i + 1));
    if (got_q.size() == 4) begin
      check("t6_data0", 32'(got_q[0].data), 32'h05);
      check("t6_data1", 32'(got_q[1].data), 32'h05);
      check("t6_data2", 32'(got_q[2].data), 32'h33);
      check("t6_data3", 32'(got_q[3].data), 32'h3F);
    end
    check("t6_op_count", 32'(op_count), 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_issuer.md
# alu_issuer

Command-side front end for the 8-bit registered ALU. Accepts operation commands `{sel, a, b, tag}` over a valid/ready interface and buffers them in a small FIFO. Issues them one at a time onto the ALU operand/select ports and captures the ALU output after its fixed latency. Returns each result, in order, on a valid/ready response port. It sits between the sequencing logic (or testbench host) and the ALU instance, and owns all timing knowledge of the ALU.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO entries (power of two, ≥2)
- `TAG_W`, 4: width of the command tag echoed on the response
- `ALU_LAT`, 1: ALU cycles from operand sample edge to valid `ALU_out`

Ports:
- `clk` input 1: single clock, all state on rising edge
- `rst_n` input 1: reset, synchronous, active-low
- `cmd_valid` input 1: command present
- `cmd_ready` output 1: `!fifo_full`, combinational from FIFO count
- `cmd_sel` input 4: ALU opcode (`alu_op_e`)
- `cmd_a`, `cmd_b` input 8: operands
- `cmd_tag` input TAG_W: opaque tag
- `alu_a`, `alu_b` output 8: registered operands to ALU `A`/`B`
- `alu_sel` output 4: registered opcode to ALU `ALU_Sel`
- `alu_out` input 8: ALU result
- `rsp_valid` output 1: response present
- `rsp_ready` input 1: consumer accepts response
- `rsp_data` output 8: result
- `rsp_err` output 1: divide-by-zero, result forced
- `rsp_tag` output TAG_W: tag of the command answered
- `busy` output 1: state ≠ IDLE or FIFO non-empty
- `op_count` output 16: responses delivered, wraps at 16'hFFFF→0

## Operation
- **Push:** on an edge with `cmd_valid && cmd_ready`, write `{sel,a,b,tag}`. A push is never accepted when full, even if a pop occurs the same edge. Simultaneous push and pop when neither full nor empty leaves the count unchanged.
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:** if the FIFO is non-empty, pop the head.
  - Normal command: load `alu_a/alu_b/alu_sel`, latch tag, go to ISSUE.
  - Command with `sel==OP_DIV` (4'b0011) and `b==0`: do not touch the ALU ports. Set `rsp_data=8'hFF`, `rsp_err=1`, go directly to RESP.
- **ISSUE:** operands are held for one cycle; the ALU samples them at the exit edge. Load `wait_cnt=ALU_LAT`, go to WAIT.
- **WAIT:** decrement each cycle. On the edge where `wait_cnt==1`, capture `alu_out` into `rsp_data`, set `rsp_err=0`, go to RESP.
- **RESP:** `rsp_valid=1`. `rsp_data/err/tag` are held stable until the edge with `rsp_ready`. On that edge, clear `rsp_valid`, increment `op_count`, go to IDLE.
- `alu_*` hold their last issued value outside ISSUE.
- The accumulating opcodes (addA, mulA, MAC) depend on internal ALU history. The issuer passes them through unmodified and models nothing.
- Responses are strictly in command order. One command is in flight at a time.

## Timing
- **Reset** (`rst_n` low at an edge): FIFO emptied, state IDLE, `alu_a=alu_b=0`, `alu_sel=0`, `rsp_valid=0`, `rsp_data=0`, `rsp_err=0`, `rsp_tag=0`, `op_count=0`. After reset, `busy=0` and `cmd_ready=1`.
- **Reset mid-operation** (any state): the in-flight command and queued commands are discarded, and no response is produced.
- **Latency** (idle, empty FIFO, accept at edge E0):
  - Pop at E1.
  - ALU samples at E2.
  - Capture at E(2+ALU_LAT).
  - `rsp_valid` high in the cycle following E(2+ALU_LAT); with ALU_LAT=1, visible after E3.
  - Div-by-zero: `rsp_valid` visible after E1.
- **Throughput:** one response per ALU_LAT+3 cycles with `rsp_ready` tied high.
- `rsp_ready` may be high before `rsp_valid`; only `rsp_valid && rsp_ready` at an edge completes the transfer.

## Structure
- **Package `alu_pkg`:**
  - `alu_op_e`: 16 opcodes, ADD=0 … LTH=15
  - `OP_DIV` constant
  - `issuer_state_e`
  - `alu_cmd_t` packed struct `{sel, a, b}`; the tag is appended in the issuer
- **Sub-module `alu_cmd_fifo`:** synchronous FIFO, DEPTH entries, with full/empty/count. Same `clk`/`rst_n`.
- `alu_issuer` contains the FSM, the wait counter, the response registers and `op_count`.

## Test plan
All cases use the ALU instance bound to `alu_issuer`, ALU_LAT=1.
1. Reset, then ADD a=8'h05 b=8'h03 tag=1 → `rsp_data=8'h08`, `rsp_tag=1`, `rsp_err=0`; `rsp_valid` visible 3 edges after accept; `op_count=1` after handshake.
2. DIV a=8'h10 b=8'h00 tag=2 → `rsp_data=8'hFF`, `rsp_err=1`, visible 1 edge after accept; `alu_sel` unchanged from its previous value.
3. `rsp_ready=0`, push 6 back-to-back commands → `cmd_ready` drops after the 5th accept (1 popped + 4 queued); raise `rsp_ready` → 6 responses in tag order; final `op_count=6`.
4. GTH a=8'hC8 b=8'h64, then LTH same operands, with `rsp_ready` held low 10 cycles → first response `8'hFF`, stable for all 10 cycles; second response `8'h00`.
5. Assert `rst_n=0` for one edge while in WAIT with 2 commands queued → next cycle all outputs at reset values, `busy=0`; no response for any of the 3 commands.
6. Accept and push on the same edge as a pop, with FIFO count 2 → count stays 2 and order is preserved; drain → tags in push order.
